ex_stage_unit: RTL and testbench
================================

Name: ex_stage_unit

Overview:
- Execute stage of the 5-stage MIPS pipeline. It consumes the 153-bit ID_EX bundle produced by the IF/ID stage.
- Functions: operand forwarding, ALU control decode, ALU operation, branch-target computation, and signed-overflow exception detection.
- Registers results into the EX_MEM bundle.
- Feeds branch and exception information back to the IF/ID stage.

Parameters:
- EXC_VECTOR, 112, PC value driven on exc_vector output during an exception (instruction 28).
- EPC_RESET, 0, reset value of the EPC register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- ID_EX  in  153  bundle fields:
  - [9:0] ctrl: b0 ALUSrc, b1 ALUOp0, b2 ALUOp1, b3 RegDst, b4 Branch, b5 MemWrite, b6 MemRead, b7 RegWrite, b8 MemtoReg, b9 Jump
  - [41:10] rs data
  - [73:42] rt data
  - [105:74] sign-extended immediate
  - [120:116] rs, [115:111] rt, [110:106] rd
  - [152:121] PC+4
- mem_wb_regwrite  in  1  WB-stage write enable
- mem_wb_rd  in  5  WB-stage destination register
- mem_wb_data  in  32  WB-stage write data
- EX_MEM  out  107  bundle fields:
  - [1:0] {MemtoReg,RegWrite}
  - [4:2] {MemRead,MemWrite,Branch}
  - [36:5] branch target
  - [37] zero
  - [69:38] ALU result
  - [101:70] store data (forwarded rt)
  - [106:102] dest reg
- beq_add  out  32  = EX_MEM[36:5]
- alu_zero_out  out  1  = EX_MEM[37]
- beq_out  out  1  = EX_MEM[2]
- exception_flush  out  1  one-cycle flush pulse
- exception_mux_control  out  1  equal to exception_flush
- exc_vector  out  32  constant EXC_VECTOR
- epc  out  32  address of the faulting instruction
- cause  out  2  00 none, 01 arithmetic overflow

Behaviour:
- Reset (async, rst_n=0): EX_MEM=0, epc=EPC_RESET, cause=0, FSM=IDLE, exception_flush=0. All derived outputs therefore read 0.
- Forwarding, operand A (rs):
  - If EX_MEM RegWrite=1 and EX_MEM dest!=0 and EX_MEM dest==rs, use EX_MEM ALU result.
  - Else if mem_wb_regwrite=1 and mem_wb_rd!=0 and mem_wb_rd==rs, use mem_wb_data.
  - Else use ID_EX rs data.
  - EX/MEM has priority over MEM/WB.
- Forwarding, operand B (rt): same rules as operand A. The forwarded rt is also the store data. The ALU B input is the immediate when ALUSrc=1.
- ALU control by {ALUOp1,ALUOp0}:
  - 00: add
  - 01: sub
  - 10: decode funct = imm[5:0]: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed). Any other funct gives result 0.
- Zero flag: zero = (result==0).
- Branch target: PC+4 + (imm<<2), mod 2^32.
- Dest reg: rd when RegDst=1, else rt.
- Overflow: signed add/sub overflow (operand signs per op, result sign differs), qualified by RegWrite=1.
- EX_MEM register:
  - Updates on every posedge clk; no stall input (load-use stalls are handled upstream by zeroing ctrl).
  - Squash (RegWrite, MemWrite, MemRead, Branch written as 0; data fields still written) when: overflow this cycle, or FSM==FLUSH.
- FSM (IDLE, FLUSH):
  - IDLE -> FLUSH on a qualified overflow. At that posedge, capture epc = PC+4 - 4 and cause = 01.
  - FLUSH -> IDLE unconditionally after one cycle.
  - exception_flush = 1 only while in FLUSH, i.e. registered, exactly one cycle, the cycle after detection.
  - An overflow arriving while in FLUSH is ignored: no epc/cause update, still squashed.
  - cause and epc hold their values until the next exception or reset.
- Reset asserted mid-FLUSH: immediately returns to IDLE and clears exception_flush.
- Jump bit (b9) is not stored in EX_MEM.

Test Plan:
- Forwarding chain:
  - Stimulus: add $3,$1,$2 with $1=5, $2=7; next cycle add $4,$3,$3 with a stale rs/rt data value of 0.
  - Required: EX_MEM ALU result = 12, then 24. EX/MEM priority holds when MEM/WB also targets $3 with value 99.
- $zero guard:
  - Stimulus: EX_MEM dest=0 with RegWrite=1, result 55; next instruction reads rs=0 with rs data 0.
  - Required: operand A = 0, no forward.
- Branch:
  - Stimulus: beq (ALUOp=01, Branch=1), rs=rt=9, PC+4=0x40, imm=3.
  - Required: beq_add=0x4C, alu_zero_out=1, beq_out=1 after the posedge. With rt=8: alu_zero_out=0.
- slt signed:
  - Stimulus: funct 101010, A=0xFFFFFFFF, B=1.
  - Required: result = 1.
- Overflow:
  - Stimulus: add with A=0x7FFFFFFF, B=1, PC+4=0x20.
  - Required: EX_MEM RegWrite=0, exception_flush=1 for exactly one cycle, epc=0x1C, cause=01. The following instruction in EX is squashed.
  - A second overflow during FLUSH leaves epc unchanged.
- Reset mid-flush:
  - Stimulus: drop rst_n during FLUSH.
  - Required: exception_flush=0 and EX_MEM=0 without waiting for a clock edge.

Source files
------------

// File: rtl/ex_stage_unit.sv
// Execute stage: operand forwarding, ALU, branch target and overflow trap.
// Registers the EX_MEM bundle and reports branch/exception state upstream.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ID_EX[152:0]           decoded instruction bundle from IF/ID
//   mem_wb_regwrite/rd/data  write-back stage forwarding source
//   EX_MEM[106:0]          registered bundle to the memory stage
//   beq_add, alu_zero_out, beq_out  branch feedback (views of EX_MEM)
//   exception_flush, exception_mux_control  one-cycle flush pulse
//   exc_vector, epc, cause exception vector, faulting PC, cause code
module ex_stage_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'd112,
    parameter logic [31:0] EPC_RESET  = 32'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [152:0] ID_EX,
    input  logic         mem_wb_regwrite,
    input  logic [4:0]   mem_wb_rd,
    input  logic [31:0]  mem_wb_data,
    output logic [106:0] EX_MEM,
    output logic [31:0]  beq_add,
    output logic         alu_zero_out,
    output logic         beq_out,
    output logic         exception_flush,
    output logic         exception_mux_control,
    output logic [31:0]  exc_vector,
    output logic [31:0]  epc,
    output logic [1:0]   cause
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_NONE
    } alu_op_t;

    state_t  state;
    alu_op_t alu_op;

    logic        alu_src;
    logic        alu_op0;
    logic        alu_op1;
    logic        reg_dst;
    logic        branch;
    logic        mem_write;
    logic        mem_read;
    logic        reg_write;
    logic        mem_to_reg;
    logic        unused_jump;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc_plus4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;

    assign alu_src     = ID_EX[0];
    assign alu_op0     = ID_EX[1];
    assign alu_op1     = ID_EX[2];
    assign reg_dst     = ID_EX[3];
    assign branch      = ID_EX[4];
    assign mem_write   = ID_EX[5];
    assign mem_read    = ID_EX[6];
    assign reg_write   = ID_EX[7];
    assign mem_to_reg  = ID_EX[8];
    assign unused_jump = ID_EX[9];
    assign rs_data     = ID_EX[41:10];
    assign rt_data     = ID_EX[73:42];
    assign imm         = ID_EX[105:74];
    assign rd          = ID_EX[110:106];
    assign rt          = ID_EX[115:111];
    assign rs          = ID_EX[120:116];
    assign pc_plus4    = ID_EX[152:121];

    logic        exm_regwrite;
    logic [4:0]  exm_dest;
    logic [31:0] exm_result;

    assign exm_regwrite = EX_MEM[0];
    assign exm_dest     = EX_MEM[106:102];
    assign exm_result   = EX_MEM[69:38];

    // The older result (MEM/WB) only wins when EX/MEM does not target the reg.
    logic a_exm;
    logic a_wb;
    logic b_exm;
    logic b_wb;

    assign a_exm = exm_regwrite && (exm_dest != 5'd0) && (exm_dest == rs);
    assign a_wb  = mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs);
    assign b_exm = exm_regwrite && (exm_dest != 5'd0) && (exm_dest == rt);
    assign b_wb  = mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == rt);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_b;

    always_comb begin
        op_a = rs_data;
        if (a_exm) begin
            op_a = exm_result;
        end else if (a_wb) begin
            op_a = mem_wb_data;
        end
    end

    always_comb begin
        op_b = rt_data;
        if (b_exm) begin
            op_b = exm_result;
        end else if (b_wb) begin
            op_b = mem_wb_data;
        end
    end

    assign alu_b = alu_src ? imm : op_b;

    // ALUOp1 selects funct decoding, as for R-type instructions.
    always_comb begin
        alu_op = OP_NONE;
        unique case ({alu_op1, alu_op0})
            2'b00:   alu_op = OP_ADD;
            2'b01:   alu_op = OP_SUB;
            default: begin
                unique case (imm[5:0])
                    6'b100000: alu_op = OP_ADD;
                    6'b100010: alu_op = OP_SUB;
                    6'b100100: alu_op = OP_AND;
                    6'b100101: alu_op = OP_OR;
                    6'b101010: alu_op = OP_SLT;
                    default:   alu_op = OP_NONE;
                endcase
            end
        endcase
    end

    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] result;
    logic        ovf_raw;

    assign sum  = op_a + alu_b;
    assign diff = op_a - alu_b;

    always_comb begin
        result  = 32'd0;
        ovf_raw = 1'b0;
        unique case (alu_op)
            OP_ADD: begin
                result  = sum;
                ovf_raw = (op_a[31] == alu_b[31]) && (sum[31] != op_a[31]);
            end
            OP_SUB: begin
                result  = diff;
                ovf_raw = (op_a[31] != alu_b[31]) && (diff[31] != op_a[31]);
            end
            OP_AND:  result = op_a & alu_b;
            OP_OR:   result = op_a | alu_b;
            OP_SLT:  result = {31'd0, $signed(op_a) < $signed(alu_b)};
            default: result = 32'd0;
        endcase
    end

    logic         overflow;
    logic         squash;
    logic [31:0]  target;
    logic [4:0]   dest;
    logic [106:0] ex_mem_d;

    assign overflow = ovf_raw && reg_write;
    assign squash   = overflow || (state == FLUSH);
    assign target   = pc_plus4 + {imm[29:0], 2'b00};
    assign dest     = reg_dst ? rd : rt;

    // Squash kills side effects only; data fields still flow through.
    assign ex_mem_d = {
        dest,
        op_b,
        result,
        (result == 32'd0),
        target,
        mem_read  && !squash,
        mem_write && !squash,
        branch    && !squash,
        mem_to_reg,
        reg_write && !squash
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_MEM          <= '0;
            state           <= IDLE;
            exception_flush <= 1'b0;
            epc             <= EPC_RESET;
            cause           <= 2'b00;
        end else begin
            EX_MEM <= ex_mem_d;
            unique case (state)
                IDLE: begin
                    if (overflow) begin
                        state           <= FLUSH;
                        exception_flush <= 1'b1;
                        epc             <= pc_plus4 - 32'd4;
                        cause           <= 2'b01;
                    end
                end
                FLUSH: begin
                    state           <= IDLE;
                    exception_flush <= 1'b0;
                end
            endcase
        end
    end

    assign beq_add               = EX_MEM[36:5];
    assign alu_zero_out          = EX_MEM[37];
    assign beq_out               = EX_MEM[2];
    assign exception_mux_control = exception_flush;
    assign exc_vector            = EXC_VECTOR;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Bench for ex_stage_unit: vector table, directed corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_ex_stage_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [152:0] id_ex;
    logic         mw_rw;
    logic [4:0]   mw_rd;
    logic [31:0]  mw_data;
    logic [106:0] ex_mem;
    logic [31:0]  beq_add;
    logic         alu_zero_out;
    logic         beq_out;
    logic         flush;
    logic         mux_ctl;
    logic [31:0]  exc_vector;
    logic [31:0]  epc;
    logic [1:0]   cause;

    always #5 clk = ~clk;

    ex_stage_unit #(
        .EXC_VECTOR(32'd112),
        .EPC_RESET (32'd0)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ID_EX                (id_ex),
        .mem_wb_regwrite      (mw_rw),
        .mem_wb_rd            (mw_rd),
        .mem_wb_data          (mw_data),
        .EX_MEM               (ex_mem),
        .beq_add              (beq_add),
        .alu_zero_out         (alu_zero_out),
        .beq_out              (beq_out),
        .exception_flush      (flush),
        .exception_mux_control(mux_ctl),
        .exc_vector           (exc_vector),
        .epc                  (epc),
        .cause                (cause)
    );

    int checks = 0;
    int passed = 0;

    // Reference state: last committed result and exception bookkeeping.
    logic        m_rw;
    logic [4:0]  m_dest;
    logic [31:0] m_res;
    logic        m_flush;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;

    task automatic chk(input string nm, input logic [106:0] act,
                       input logic [106:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [152:0] mk(
        input logic [9:0] c, input logic [31:0] rsd, input logic [31:0] rtd,
        input logic [31:0] im, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [31:0] pc4);
        return {pc4, rs, rt, rd, im, rtd, rsd, c};
    endfunction

    function automatic logic [31:0] pick(input logic [4:0] r,
        input logic [31:0] dflt, input logic wrw, input logic [4:0] wrd,
        input logic [31:0] wdat);
        if (m_rw && m_dest != 0 && m_dest == r) return m_res;
        if (wrw && wrd != 0 && wrd == r) return wdat;
        return dflt;
    endfunction

    function automatic logic [106:0] model(input logic [152:0] x,
        input logic wrw, input logic [4:0] wrd, input logic [31:0] wdat,
        output logic ovf);
        logic [9:0]  c;
        logic [31:0] a, b, bo, im, res, pc4;
        logic [4:0]  dst;
        longint      w;
        bit          arith;
        bit          sq;
        c   = x[9:0];
        im  = x[105:74];
        pc4 = x[152:121];
        a   = pick(x[120:116], x[41:10], wrw, wrd, wdat);
        b   = pick(x[115:111], x[73:42], wrw, wrd, wdat);
        bo  = c[0] ? im : b;
        arith = 1'b0;
        res = 0;
        w   = 0;
        if (c[2:1] == 2'b00) begin
            arith = 1; w = longint'($signed(a)) + longint'($signed(bo));
        end else if (c[2:1] == 2'b01) begin
            arith = 1; w = longint'($signed(a)) - longint'($signed(bo));
        end else begin
            case (im[5:0])
                6'h20: begin arith = 1; w = longint'($signed(a)) + longint'($signed(bo)); end
                6'h22: begin arith = 1; w = longint'($signed(a)) - longint'($signed(bo)); end
                6'h24: res = a & bo;
                6'h25: res = a | bo;
                6'h2A: res = ($signed(a) < $signed(bo)) ? 32'd1 : 32'd0;
                default: res = 0;
            endcase
        end
        ovf = 1'b0;
        if (arith) begin
            res = w[31:0];
            ovf = (w != longint'($signed(res))) && c[7];
        end
        sq  = ovf || m_flush;
        dst = c[3] ? x[110:106] : x[115:111];
        return {dst, b, res, res == 0, pc4 + (im << 2),
                c[6] & ~sq, c[5] & ~sq, c[4] & ~sq, c[8], c[7] & ~sq};
    endfunction

    task automatic step(input logic [152:0] x, input logic wrw,
                        input logic [4:0] wrd, input logic [31:0] wdat);
        logic [106:0] e;
        logic         ovf;
        id_ex   = x;
        mw_rw   = wrw;
        mw_rd   = wrd;
        mw_data = wdat;
        e = model(x, wrw, wrd, wdat, ovf);
        @(posedge clk);
        #1;
        m_rw   = e[0];
        m_dest = e[106:102];
        m_res  = e[69:38];
        if (!m_flush && ovf) begin
            m_flush = 1'b1;
            m_epc   = x[152:121] - 32'd4;
            m_cause = 2'b01;
        end else begin
            m_flush = 1'b0;
        end
        chk("ex_mem", ex_mem, e);
        chk("flush", flush, m_flush);
        chk("mux_ctl", mux_ctl, m_flush);
        chk("epc", epc, m_epc);
        chk("cause", cause, m_cause);
    endtask

    task automatic model_reset();
        m_rw = 0; m_dest = 0; m_res = 0;
        m_flush = 0; m_epc = 0; m_cause = 0;
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'd1;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [9:0]  ctrl;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [31:0] exp_res;
        logic        exp_zero;
    } tv_t;

    tv_t tv[10];

    localparam logic [9:0] RTYPE = 10'h08C;

    initial begin
        logic [9:0]  c;
        logic [31:0] im;
        logic [5:0]  functs[6];

        tv[0] = '{10'h00C, 32'd3, 32'd4, 32'h20, 32'd7, 1'b0};
        tv[1] = '{10'h00C, 32'd3, 32'd4, 32'h22, 32'hFFFFFFFF, 1'b0};
        tv[2] = '{10'h00C, 32'hF0F0F0F0, 32'hFF00FF00, 32'h24, 32'hF000F000, 1'b0};
        tv[3] = '{10'h00C, 32'h0F0F0000, 32'h000000F0, 32'h25, 32'h0F0F00F0, 1'b0};
        tv[4] = '{10'h00C, 32'd5, 32'd3, 32'h2A, 32'd0, 1'b1};
        tv[5] = '{10'h00C, 32'h80000000, 32'h7FFFFFFF, 32'h2A, 32'd1, 1'b0};
        tv[6] = '{10'h00C, 32'd5, 32'd3, 32'h27, 32'd0, 1'b1};
        tv[7] = '{10'h001, 32'd100, 32'd0, 32'hFFFFFFFC, 32'd96, 1'b0};
        tv[8] = '{10'h002, 32'd9, 32'd9, 32'd0, 32'd0, 1'b1};
        tv[9] = '{10'h00C, 32'h7FFFFFFF, 32'd1, 32'h20, 32'h80000000, 1'b0};

        functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
        functs[3] = 6'h25; functs[4] = 6'h2A; functs[5] = 6'h07;

        rst_n = 1'b0;
        id_ex = '0; mw_rw = 0; mw_rd = 0; mw_data = 0;
        model_reset();
        #12;
        chk("rst_ex_mem", ex_mem, 0);
        chk("rst_flush", flush, 0);
        chk("rst_epc", epc, 0);
        chk("rst_cause", cause, 0);
        chk("exc_vector", exc_vector, 32'd112);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(mk(tv[i].ctrl, tv[i].rsd, tv[i].rtd, tv[i].imm,
                    5'd20, 5'd21, 5'd22, 32'h200 + 32'(i * 4)), 0, 0, 0);
            chk($sformatf("tv%0d_res", i), ex_mem[69:38], tv[i].exp_res);
            chk($sformatf("tv%0d_zero", i), ex_mem[37], tv[i].exp_zero);
        end

        // Forwarding chain and EX/MEM over MEM/WB priority.
        step(mk(RTYPE, 5, 7, 32'h20, 1, 2, 3, 32'h100), 0, 0, 0);
        chk("fwd_first", ex_mem[69:38], 12);
        step(mk(RTYPE, 0, 0, 32'h20, 3, 3, 4, 32'h104), 1, 3, 99);
        chk("fwd_prio", ex_mem[69:38], 24);
        step(mk(RTYPE, 0, 0, 32'h20, 3, 0, 5, 32'h108), 1, 3, 99);
        chk("fwd_wb", ex_mem[69:38], 99);

        // Writes to $zero are never forwarded.
        step(mk(RTYPE, 55, 0, 32'h20, 1, 0, 0, 32'h10C), 0, 0, 0);
        chk("zero_dest", ex_mem[69:38], 55);
        step(mk(RTYPE, 0, 0, 32'h20, 0, 0, 6, 32'h110), 1, 0, 77);
        chk("zero_guard", ex_mem[69:38], 0);

        // Branch.
        step(mk(10'h012, 9, 9, 3, 1, 2, 0, 32'h40), 0, 0, 0);
        chk("beq_add", beq_add, 32'h4C);
        chk("beq_zero", alu_zero_out, 1);
        chk("beq_out", beq_out, 1);
        step(mk(10'h012, 9, 8, 3, 1, 2, 0, 32'h40), 0, 0, 0);
        chk("bne_zero", alu_zero_out, 0);

        // Signed slt.
        step(mk(RTYPE, 32'hFFFFFFFF, 1, 32'h2A, 7, 8, 9, 32'h50), 0, 0, 0);
        chk("slt_signed", ex_mem[69:38], 1);

        // Overflow, squash of the follower, overflow during FLUSH.
        step(mk(RTYPE, 32'h7FFFFFFF, 1, 32'h20, 10, 11, 12, 32'h20), 0, 0, 0);
        chk("ovf_regwrite", ex_mem[0], 0);
        chk("ovf_flush", flush, 1);
        chk("ovf_epc", epc, 32'h1C);
        chk("ovf_cause", cause, 2'b01);
        step(mk(RTYPE, 1, 2, 32'h20, 1, 2, 3, 32'h24), 0, 0, 0);
        chk("squash_rw", ex_mem[0], 0);
        chk("flush_one", flush, 0);
        step(mk(RTYPE, 32'h7FFFFFFF, 1, 32'h20, 10, 11, 12, 32'h60), 0, 0, 0);
        chk("ovf2_epc", epc, 32'h5C);
        step(mk(RTYPE, 32'h80000000, 1, 32'h22, 13, 14, 15, 32'h80), 0, 0, 0);
        chk("ovf_in_flush_epc", epc, 32'h5C);
        chk("ovf_in_flush_rw", ex_mem[0], 0);
        step(mk(RTYPE, 32'h7FFFFFFF, 1, 32'h20, 10, 11, 12, 32'h90), 0, 0, 0);
        chk("ovf3_epc", epc, 32'h8C);

        // Asynchronous reset while flushing.
        rst_n = 1'b0;
        #1;
        chk("midrst_flush", flush, 0);
        chk("midrst_ex_mem", ex_mem, 0);
        chk("midrst_epc", epc, 0);
        model_reset();
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            c = 10'($urandom);
            c[2:1] = 2'($urandom_range(0, 2));
            im = rv();
            if ($urandom_range(0, 3) != 0) im[5:0] = functs[$urandom_range(0, 5)];
            step(mk(c, rv(), rv(), im, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom),
                 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
